// File: rtl/mem_bus_arb.sv
// Shares one memory bus between instruction fetch and load/store, one transaction in flight.
// Define ARB_STARVE_EN to force an IF win after STARVE_MAX consecutive contested LSU wins.
module mem_bus_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                if_flush,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                arb2ac_lsu_hazard
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state;
  logic              owner_lsu;
  logic              kill;
  logic [ADDR_W-1:0] addr_p1;
  logic              wen_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [STRB_W-1:0] wstrb_p1;

  logic idle;
  logic if_ok;
  logic force_if;
  logic grant_if;
  logic grant_lsu;
  logic in_data;
  logic rsp_fire;

  // Grants are suppressed while rst is high so no requester sees a phantom accept.
  assign idle      = (state == S_IDLE) & ~rst;
  assign if_ok     = if_req_valid & ~if_flush;
  assign grant_if  = idle & if_ok & (~lsu_req_valid | force_if);
  assign grant_lsu = idle & lsu_req_valid & ~grant_if;

`ifdef ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

  // Saturates at STARVE_MAX when a flushed IF lets LSU keep winning.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_lsu && if_req_valid && !force_if) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  // Fixed LSU priority; STARVE_MAX has no role in this build.
  assign force_if = (STARVE_MAX < 0);
`endif

  // Stage p0 -> p1: grant latches owner and bus payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_lsu <= 1'b0;
      kill      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_if || grant_lsu) begin
            state     <= S_ADDR;
            owner_lsu <= grant_lsu;
            kill      <= 1'b0;
          end
        end
        S_ADDR: begin
          if (!owner_lsu && if_flush) kill <= 1'b1;
          if (mem_req_ready) state <= S_DATA;
        end
        S_DATA: begin
          if (mem_rsp_valid) begin
            state <= S_IDLE;
            kill  <= 1'b0;
          end else if (!owner_lsu && if_flush) begin
            kill <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant_lsu) begin
      addr_p1  <= lsu_req_addr;
      wen_p1   <= lsu_req_wen;
      wdata_p1 <= lsu_req_wdata;
      wstrb_p1 <= lsu_req_wstrb;
    end else if (grant_if) begin
      addr_p1  <= if_req_addr;
      wen_p1   <= 1'b0;
      wdata_p1 <= '0;
      wstrb_p1 <= '0;
    end
  end

  // Stage p1 -> p2: bus request phase, then same-cycle response routing
  assign if_req_ready  = grant_if;
  assign lsu_req_ready = grant_lsu;

  assign mem_req_valid = (state == S_ADDR);
  assign mem_req_addr  = mem_req_valid ? addr_p1  : '0;
  assign mem_req_wen   = mem_req_valid & wen_p1;
  assign mem_req_wdata = mem_req_valid ? wdata_p1 : '0;
  assign mem_req_wstrb = mem_req_valid ? wstrb_p1 : '0;

  // A flush arriving with the response still kills it; the bus cannot be recalled.
  assign in_data       = (state == S_DATA);
  assign rsp_fire      = in_data & mem_rsp_valid;
  assign if_rsp_valid  = rsp_fire & ~owner_lsu & ~kill & ~if_flush;
  assign lsu_rsp_valid = rsp_fire & owner_lsu;
  assign if_rsp_data   = (in_data & ~owner_lsu) ? mem_rsp_data : '0;
  assign lsu_rsp_data  = (in_data & owner_lsu)  ? mem_rsp_data : '0;

  assign arb2ac_lsu_hazard = (lsu_req_valid | (owner_lsu & (state != S_IDLE))) & ~lsu_rsp_valid;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Self-checking bench for mem_bus_arb: directed scenarios plus a randomized run against a
// transaction-level reference model. Honours ARB_STARVE_EN the same way the design does.
module tb_mem_bus_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STARVE_MAX = 4;
  localparam int SW = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_rsp_valid, if_flush;
  logic [ADDR_W-1:0] if_req_addr;
  logic [DATA_W-1:0] if_rsp_data;
  logic              lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic [DATA_W-1:0] lsu_req_wdata, lsu_rsp_data;
  logic [SW-1:0]     lsu_req_wstrb;
  logic              mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata, mem_rsp_data;
  logic [SW-1:0]     mem_req_wstrb;
  logic              arb2ac_lsu_hazard;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_flush(if_flush),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .arb2ac_lsu_hazard(arb2ac_lsu_hazard)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wstrb = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
    #2;
    checks++;
    if ({if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_req_wen,
         arb2ac_lsu_hazard} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {if_req_ready, lsu_req_ready, if_rsp_valid,
               lsu_rsp_valid, mem_req_valid, mem_req_wen, arb2ac_lsu_hazard});
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wstrb, if_rsp_data, lsu_rsp_data} !== '0) begin
      failures++;
      $display("FAIL reset_buses got=%h exp=0",
               {mem_req_addr, mem_req_wdata, mem_req_wstrb, if_rsp_data, lsu_rsp_data});
    end
    tick();
  endtask

  task automatic test_if_fetch();
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    #2;
    checks++;
    if ({if_req_ready, lsu_req_ready, arb2ac_lsu_hazard} !== 3'b100) begin
      failures++;
      $display("FAIL fetch_grant got=%b exp=100", {if_req_ready, lsu_req_ready, arb2ac_lsu_hazard});
    end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    #2;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb} !== {1'b1, 32'h100, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL fetch_addr got=%b/%h/%b/%h exp=1/100/0/0", mem_req_valid, mem_req_addr,
               mem_req_wen, mem_req_wstrb);
    end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    #2;
    checks++;
    if ({mem_req_valid, if_rsp_valid, lsu_rsp_valid, arb2ac_lsu_hazard} !== 4'b0100 ||
        if_rsp_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fetch_rsp got=%b data=%h exp=0100 data=deadbeef",
               {mem_req_valid, if_rsp_valid, lsu_rsp_valid, arb2ac_lsu_hazard}, if_rsp_data);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #2;
    checks++;
    if ({if_rsp_valid, mem_req_valid} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_pulse got=%b exp=00", {if_rsp_valid, mem_req_valid});
    end
    tick();
  endtask

  task automatic test_contention();
    if_req_valid = 1'b1; if_req_addr = 32'h300;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h200; lsu_req_wen = 1'b0;
    #2;
    checks++;
    if ({lsu_req_ready, if_req_ready, arb2ac_lsu_hazard} !== 3'b101) begin
      failures++;
      $display("FAIL contend_grant got=%b exp=101", {lsu_req_ready, if_req_ready, arb2ac_lsu_hazard});
    end
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #2;
    checks++;
    if ({mem_req_addr, if_req_ready, arb2ac_lsu_hazard} !== {32'h200, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL contend_addr got=%h/%b/%b exp=200/0/1", mem_req_addr, if_req_ready,
               arb2ac_lsu_hazard);
    end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE0001;
    #2;
    checks++;
    if ({lsu_rsp_valid, if_rsp_valid, arb2ac_lsu_hazard, if_req_ready} !== 4'b1000 ||
        lsu_rsp_data !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL contend_rsp got=%b data=%h exp=1000 data=cafe0001",
               {lsu_rsp_valid, if_rsp_valid, arb2ac_lsu_hazard, if_req_ready}, lsu_rsp_data);
    end
    tick();
    mem_rsp_valid = 1'b0;
    #2;
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL contend_if_next got=%b exp=1", if_req_ready);
    end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    #2;
    checks++;
    if (mem_req_addr !== 32'h300) begin
      failures++;
      $display("FAIL contend_if_addr got=%h exp=300", mem_req_addr);
    end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BADF00D;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_write_stall();
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h400;
    lsu_req_wdata = 32'h12345678; lsu_req_wstrb = 4'b0011;
    #2;
    checks++;
    if (lsu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_grant got=%b exp=1", lsu_req_ready);
    end
    tick();
    lsu_req_valid = 1'b0; lsu_req_addr = 32'hFFFF0000; lsu_req_wdata = 32'hFFFFFFFF;
    lsu_req_wstrb = 4'hF; lsu_req_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      #2;
      checks++;
      if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb} !==
          {1'b1, 1'b1, 32'h400, 32'h12345678, 4'b0011}) begin
        failures++;
        $display("FAIL wr_hold%0d got=%b/%b/%h/%h/%b exp=1/1/400/12345678/0011", i, mem_req_valid,
                 mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb);
      end
      tick();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA;
    #2;
    checks++;
    if ({lsu_rsp_valid, if_rsp_valid, mem_req_valid} !== 3'b100) begin
      failures++;
      $display("FAIL wr_ack got=%b exp=100", {lsu_rsp_valid, if_rsp_valid, mem_req_valid});
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    if_req_valid = 1'b1; if_req_addr = 32'h480; if_flush = 1'b1;
    #2;
    checks++;
    if (if_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_grant got=%b exp=0", if_req_ready);
    end
    tick();
    if_flush = 1'b0; if_req_addr = 32'h500;
    #2;
    checks++;
    if ({mem_req_valid, if_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL flush_regrant got=%b exp=01", {mem_req_valid, if_req_ready});
    end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; if_flush = 1'b1;
    #2;
    checks++;
    if (if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_data_idle got=%b exp=0", if_rsp_valid);
    end
    tick();
    if_flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11112222;
    #2;
    checks++;
    if (if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_killed got=%b exp=0", if_rsp_valid);
    end
    tick();
    mem_rsp_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h600;
    #2;
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_next_grant got=%b exp=1", if_req_ready);
    end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h33334444;
    #2;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h33334444) begin
      failures++;
      $display("FAIL flush_kill_clear got=%b/%h exp=1/33334444", if_rsp_valid, if_rsp_data);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h700;
    tick();
    lsu_req_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if ({mem_req_valid, arb2ac_lsu_hazard, mem_req_addr} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%b/%h exp=0/0/0", mem_req_valid, arb2ac_lsu_hazard,
               mem_req_addr);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h99887766;
      #2;
      checks++;
      if ({if_rsp_valid, lsu_rsp_valid, if_rsp_data, lsu_rsp_data, mem_req_valid} !== '0) begin
        failures++;
        $display("FAIL rstmid_stray%0d got=%b/%b/%h/%h/%b exp=0", i, if_rsp_valid, lsu_rsp_valid,
                 if_rsp_data, lsu_rsp_data, mem_req_valid);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_priority();
    logic exp_lsu;
    if_req_valid = 1'b1; if_req_addr = 32'hA00;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'hB00; lsu_req_wen = 1'b0;
    for (int g = 0; g < 5; g++) begin
`ifdef ARB_STARVE_EN
      exp_lsu = (g < STARVE_MAX);
`else
      exp_lsu = 1'b1;
`endif
      #2;
      checks++;
      if ({lsu_req_ready, if_req_ready} !== {exp_lsu, ~exp_lsu}) begin
        failures++;
        $display("FAIL prio_grant%0d got=%b exp=%b", g, {lsu_req_ready, if_req_ready},
                 {exp_lsu, ~exp_lsu});
      end
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'($urandom);
      #2;
      checks++;
      if ({lsu_rsp_valid, if_rsp_valid} !== {exp_lsu, ~exp_lsu}) begin
        failures++;
        $display("FAIL prio_rsp%0d got=%b exp=%b", g, {lsu_rsp_valid, if_rsp_valid},
                 {exp_lsu, ~exp_lsu});
      end
      tick();
      mem_rsp_valid = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  // Reference model: one transaction at a time; LSU beats IF unless IF has lost
  // STARVE_MAX contested grants; flushed fetches still occupy the bus but return nothing.
  task automatic test_random();
    logic busy, accepted, own_lsu, killed;
    logic g_if, g_lsu, force_if, e_if_rsp, e_lsu_rsp, e_haz;
    logic [ADDR_W-1:0] e_addr;
    logic e_wen;
    logic [DATA_W-1:0] e_wdata;
    logic [SW-1:0] e_wstrb;
`ifdef ARB_STARVE_EN
    int losses = 0;
`endif
    busy = 1'b0; accepted = 1'b0; own_lsu = 1'b0; killed = 1'b0;
    e_addr = '0; e_wen = 1'b0; e_wdata = '0; e_wstrb = '0;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if_req_valid  = ($urandom_range(0, 2) != 0);
      if_req_addr   = 32'($urandom);
      if_flush      = ($urandom_range(0, 5) == 0);
      lsu_req_valid = ($urandom_range(0, 2) == 0);
      lsu_req_addr  = 32'($urandom);
      lsu_req_wen   = 1'($urandom_range(0, 1));
      lsu_req_wdata = 32'($urandom);
      lsu_req_wstrb = SW'($urandom);
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = (busy && accepted) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      mem_rsp_data  = 32'($urandom);

      force_if = 1'b0;
`ifdef ARB_STARVE_EN
      force_if = (losses == STARVE_MAX);
`endif
      g_if  = !busy && if_req_valid && !if_flush && (!lsu_req_valid || force_if);
      g_lsu = !busy && lsu_req_valid && !g_if;
      e_if_rsp  = busy && accepted && mem_rsp_valid && !own_lsu && !killed && !if_flush;
      e_lsu_rsp = busy && accepted && mem_rsp_valid && own_lsu;
      e_haz     = (lsu_req_valid || (busy && own_lsu)) && !e_lsu_rsp;
      #2;
      checks++;
      if ({if_req_ready, lsu_req_ready} !== {g_if, g_lsu}) begin
        failures++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, {if_req_ready, lsu_req_ready}, {g_if, g_lsu});
      end
      checks++;
      if (mem_req_valid !== (busy && !accepted)) begin
        failures++;
        $display("FAIL rnd_memvalid c=%0d got=%b exp=%b", c, mem_req_valid, busy && !accepted);
      end
      if (busy && !accepted) begin
        checks++;
        if (mem_req_addr !== e_addr || mem_req_wen !== e_wen || mem_req_wstrb !== e_wstrb ||
            (e_wen && mem_req_wdata !== e_wdata)) begin
          failures++;
          $display("FAIL rnd_payload c=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", c, mem_req_addr,
                   mem_req_wen, mem_req_wdata, mem_req_wstrb, e_addr, e_wen, e_wdata, e_wstrb);
        end
      end
      checks++;
      if ({if_rsp_valid, lsu_rsp_valid} !== {e_if_rsp, e_lsu_rsp}) begin
        failures++;
        $display("FAIL rnd_rspvalid c=%0d got=%b exp=%b", c, {if_rsp_valid, lsu_rsp_valid},
                 {e_if_rsp, e_lsu_rsp});
      end
      if (e_if_rsp || e_lsu_rsp) begin
        checks++;
        if ((e_if_rsp ? if_rsp_data : lsu_rsp_data) !== mem_rsp_data) begin
          failures++;
          $display("FAIL rnd_rspdata c=%0d got=%h exp=%h", c,
                   e_if_rsp ? if_rsp_data : lsu_rsp_data, mem_rsp_data);
        end
      end
      checks++;
      if (arb2ac_lsu_hazard !== e_haz) begin
        failures++;
        $display("FAIL rnd_hazard c=%0d got=%b exp=%b", c, arb2ac_lsu_hazard, e_haz);
      end

      if (!busy) begin
        if (g_if || g_lsu) begin
          busy = 1'b1; accepted = 1'b0; own_lsu = g_lsu; killed = 1'b0;
          e_addr  = g_lsu ? lsu_req_addr : if_req_addr;
          e_wen   = g_lsu && lsu_req_wen;
          e_wdata = lsu_req_wdata;
          e_wstrb = g_lsu ? lsu_req_wstrb : '0;
        end
`ifdef ARB_STARVE_EN
        if (g_if) losses = 0;
        else if (g_lsu && if_req_valid && losses < STARVE_MAX) losses++;
`endif
      end else if (!accepted) begin
        if (!own_lsu && if_flush) killed = 1'b1;
        if (mem_req_ready) accepted = 1'b1;
      end else if (mem_rsp_valid) begin
        busy = 1'b0;
      end else if (!own_lsu && if_flush) begin
        killed = 1'b1;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_if_fetch();
    test_contention();
    test_write_stall();
    test_flush();
    test_reset_mid();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
